// File: rtl/rsa_pkg.sv
// Shared types for the RSA modular exponentiation controller.
// Holds the controller FSM enum, the mod_mult FSM enum and its handshake bundle.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REDUCE,
    SQR,
    MUL,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    M_IDLE,
    M_R2,
    M_MONT1,
    M_MONT2
  } mm_state_t;

  typedef struct packed {
    logic clear;
    logic start;
  } mm_ctl_t;

endpackage

// File: rtl/mod_mult.sv
// Bit-serial Montgomery modular multiplier: p = a*b mod m (m odd).
// Ports: clk, rst, clear, start, a, b, m (in); done pulse, p (out).
module mod_mult
  import rsa_pkg::*;
#(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH) + 1;

  mm_state_t        ms;
  logic [WIDTH-1:0] pa;
  logic [WIDTH-1:0] pb;
  logic [WIDTH-1:0] mr;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] r2;
  logic [WIDTH-1:0] r2_m;
  logic             r2_ok;
  logic [WIDTH+1:0] u;
  logic [CW-1:0]    cnt;

  // R^2 mod m by repeated doubling; x < m always holds.
  logic [WIDTH:0]   dbl;
  logic [WIDTH-1:0] x_nxt;
  assign dbl   = {x, 1'b0};
  assign x_nxt = (dbl >= {1'b0, mr}) ? WIDTH'(dbl - {1'b0, mr})
                                     : dbl[WIDTH-1:0];

  // One radix-2 Montgomery step. u stays below pb+m, so only the
  // multiplier operand (pa) may exceed m.
  logic [WIDTH+1:0] s1;
  logic [WIDTH+1:0] s2;
  logic [WIDTH+1:0] u_nxt;
  logic [WIDTH+1:0] u_red;
  logic             last;
  assign s1    = u + (pa[0] ? {2'b00, pb} : '0);
  assign s2    = s1[0] ? s1 + {2'b00, mr} : s1;
  assign u_nxt = s2 >> 1;
  assign u_red = (u_nxt >= {2'b00, mr}) ? u_nxt - {2'b00, mr} : u_nxt;
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst || clear) begin
      ms  <= M_IDLE;
      pa  <= '0;
      pb  <= '0;
      mr  <= '0;
      x   <= '0;
      u   <= '0;
      cnt <= '0;
      if (rst) begin
        p     <= '0;
        r2    <= '0;
        r2_m  <= '0;
        r2_ok <= 1'b0;
      end
    end else begin
      unique case (ms)
        M_IDLE: if (start) begin
          pa  <= a;
          pb  <= b;
          mr  <= m;
          u   <= '0;
          cnt <= '0;
          // R^2 mod m is reused while the modulus is unchanged.
          if (r2_ok && r2_m == m) begin
            ms <= M_MONT1;
          end else begin
            x  <= (m == WIDTH'(1)) ? '0 : WIDTH'(1);
            ms <= M_R2;
          end
        end
        M_R2: begin
          x   <= x_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(2 * WIDTH - 1)) begin
            r2    <= x_nxt;
            r2_m  <= mr;
            r2_ok <= 1'b1;
            cnt   <= '0;
            ms    <= M_MONT1;
          end
        end
        M_MONT1: begin
          u   <= u_nxt;
          pa  <= pa >> 1;
          cnt <= cnt + CW'(1);
          // a*b*R^-1, then times R^2 to leave the Montgomery domain.
          if (last) begin
            pa  <= u_red[WIDTH-1:0];
            pb  <= r2;
            u   <= '0;
            cnt <= '0;
            ms  <= M_MONT2;
          end
        end
        M_MONT2: begin
          u   <= u_nxt;
          pa  <= pa >> 1;
          cnt <= cnt + CW'(1);
          if (last) begin
            p    <= u_red[WIDTH-1:0];
            done <= 1'b1;
            cnt  <= '0;
            ms   <= M_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply controller around one mod_mult.
// In: clk, rst, start, base, exponent, modulus, abort, out_ready.
// Out: in_ready, busy, out_valid, result, error, mult_count.
module rsa_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH        = 1024,
  parameter int ODD_MOD_ONLY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         base,
  input  logic [WIDTH-1:0]         exponent,
  input  logic [WIDTH-1:0]         modulus,
  input  logic                     abort,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     error,
  output logic [$clog2(WIDTH)+1:0] mult_count
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 2;

  state_t           state;
  logic [WIDTH-1:0] base_r;
  logic [WIDTH-1:0] exp_r;
  logic [WIDTH-1:0] mod_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base_red;
  logic [IW-1:0]    idx;
  logic             pend;
  logic             mstart;

  logic             active;
  logic             kill;
  logic             bad_mod;
  mm_ctl_t          ctl;
  logic             mm_done;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_p;

  assign active  = (state == SCAN) || (state == REDUCE) ||
                   (state == SQR)  || (state == MUL);
  assign kill    = abort && active;
  assign bad_mod = (modulus == '0) ||
                   ((ODD_MOD_ONLY != 0) && !modulus[0]);

  // Clear is combinational so the multiplier drops its work on the
  // same edge the FSM returns to IDLE.
  assign ctl.clear = kill;
  assign ctl.start = mstart;

  always_comb begin
    mm_a = acc;
    mm_b = acc;
    if (state == REDUCE) begin
      mm_a = base_r;
      mm_b = WIDTH'(1);
    end else if (state == MUL) begin
      mm_b = base_red;
    end
  end

  mod_mult #(.WIDTH(WIDTH)) u_mm (
    .clk   (clk),
    .rst   (rst),
    .clear (ctl.clear),
    .start (ctl.start),
    .a     (mm_a),
    .b     (mm_b),
    .m     (mod_r),
    .done  (mm_done),
    .p     (mm_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      error      <= 1'b0;
      result     <= '0;
      mult_count <= '0;
      base_r     <= '0;
      exp_r      <= '0;
      mod_r      <= '0;
      acc        <= '0;
      base_red   <= '0;
      idx        <= '0;
      pend       <= 1'b0;
      mstart     <= 1'b0;
    end else begin
      mstart <= 1'b0;
      if (kill) begin
        state    <= IDLE;
        in_ready <= 1'b1;
        busy     <= 1'b0;
        pend     <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            base_r     <= base;
            exp_r      <= exponent;
            mod_r      <= modulus;
            mult_count <= '0;
            idx        <= IW'(WIDTH - 1);
            in_ready   <= 1'b0;
            error      <= 1'b0;
            if (bad_mod) begin
              state     <= DONE;
              error     <= 1'b1;
              result    <= '0;
              out_valid <= 1'b1;
            end else begin
              state <= SCAN;
              busy  <= 1'b1;
            end
          end
          SCAN: begin
            if (exp_r[idx]) begin
              state <= REDUCE;
            end else if (idx == '0) begin
              state     <= DONE;
              result    <= (mod_r == WIDTH'(1)) ? '0 : WIDTH'(1);
              out_valid <= 1'b1;
              busy      <= 1'b0;
            end else begin
              idx <= idx - IW'(1);
            end
          end
          REDUCE, SQR, MUL: begin
            if (!pend) begin
              mstart     <= 1'b1;
              pend       <= 1'b1;
              mult_count <= mult_count + CW'(1);
            end else if (mm_done) begin
              pend <= 1'b0;
              acc  <= mm_p;
              if (state == REDUCE) base_red <= mm_p;
              if (state == SQR && exp_r[idx]) begin
                state <= MUL;
              end else if (idx == '0) begin
                state     <= DONE;
                result    <= mm_p;
                out_valid <= 1'b1;
                busy      <= 1'b0;
              end else begin
                idx   <= idx - IW'(1);
                state <= SQR;
              end
            end
          end
          DONE: if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Self-checking bench for rsa_modexp_ctrl at WIDTH=16.
// Arithmetic reference model plus per-cycle output compare.
module tb_rsa_modexp_ctrl;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   base = '0;
  logic [W-1:0]   exponent = '0;
  logic [W-1:0]   modulus = '0;
  logic           in_ready;
  logic           busy;
  logic           out_valid;
  logic           error;
  logic [W-1:0]   result;
  logic [$clog2(W)+1:0] mult_count;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] e_res = '0;
  logic [W-1:0] last_res = '0;
  logic         e_err = 1'b0;
  int           e_cnt = 0;
  bit           e_live = 1'b0;

  rsa_modexp_ctrl #(.WIDTH(W), .ODD_MOD_ONLY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_ready   (in_ready),
    .base       (base),
    .exponent   (exponent),
    .modulus    (modulus),
    .abort      (abort),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .error      (error),
    .mult_count (mult_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint unsigned mexp(input logic [W-1:0] b,
                                           input logic [W-1:0] e,
                                           input logic [W-1:0] m);
    longint unsigned r, x, mm;
    mm = m;
    r = 1 % mm;
    x = b % mm;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r;
  endfunction

  function automatic int nops(input logic [W-1:0] e);
    int k, pc;
    k = -1;
    pc = 0;
    for (int i = 0; i < W; i++)
      if (e[i]) begin
        k = i;
        pc++;
      end
    return (k < 0) ? 0 : k + pc;
  endfunction

  task automatic set_model(input logic [W-1:0] b, input logic [W-1:0] e,
                           input logic [W-1:0] m);
    if (m == '0 || !m[0]) begin
      e_err = 1'b1;
      e_res = '0;
      e_cnt = 0;
    end else begin
      e_err = 1'b0;
      e_res = W'(mexp(b, e, m));
      e_cnt = nops(e);
    end
    e_live = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!e_live) begin
        chk("valid_expected", {63'd0, e_live}, 64'd1);
      end else begin
        chk("result", result, e_res);
        chk("error", error, e_err);
        chk("mult_count", mult_count, e_cnt);
      end
    end
  end

  task automatic issue(input logic [W-1:0] b, input logic [W-1:0] e,
                       input logic [W-1:0] m);
    int t;
    t = 0;
    while (!in_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", in_ready, 1);
    set_model(b, e, m);
    base = b;
    exponent = e;
    modulus = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("accept_in_ready_low", in_ready, 0);
    if (!e_err) chk("busy_after_accept", busy, 1);
  endtask

  task automatic consume(input int stall, input bit poke, output int lat);
    int t;
    t = 0;
    while (!out_valid && t < 5000) begin
      @(negedge clk);
      t++;
    end
    lat = t;
    chk("out_valid_wait", out_valid, 1);
    for (int i = 0; i < stall; i++) begin
      start = poke;
      base = W'(i);
      exponent = W'(1);
      modulus = W'(3);
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    last_res = e_res;
    e_live = 1'b0;
    chk("consumed_valid_low", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int lat, t;
    logic [W-1:0] rb, re, rm;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_error", error, 0);
    chk("rst_result", result, 0);
    chk("rst_mult_count", mult_count, 0);
    rst = 1'b0;
    @(negedge clk);

    chk("pin_4_13_497", mexp(16'd4, 16'd13, 16'd497), 445);
    chk("pin_5_3_13", mexp(16'd5, 16'd3, 16'd13), 8);
    chk("pin_500_1_497", mexp(16'd500, 16'd1, 16'd497), 3);
    chk("pin_exp0_mod1", mexp(16'd7, 16'd0, 16'd1), 0);
    chk("pin_exp0", mexp(16'd7, 16'd0, 16'd497), 1);
    chk("pin_ops_13", nops(16'd13), 6);

    issue(16'd4, 16'd13, 16'd497);
    consume(0, 1'b0, lat);
    chk("r029_result", result, 445);

    issue(16'd7, 16'd0, 16'd497);
    consume(0, 1'b0, lat);
    chk("exp0_result", result, 1);
    issue(16'd7, 16'd0, 16'd1);
    consume(0, 1'b0, lat);
    chk("exp0_mod1_result", result, 0);

    issue(16'd3, 16'd5, 16'd496);
    consume(0, 1'b0, lat);
    chk("even_mod_latency", lat <= 2, 1);
    issue(16'd3, 16'd5, 16'd0);
    consume(0, 1'b0, lat);
    chk("zero_mod_latency", lat <= 2, 1);

    issue(16'd4, 16'd13, 16'd497);
    t = 0;
    while (mult_count != 4 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_second_sqr", mult_count, 4);
    abort = 1'b1;
    e_live = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_result_hold", result, last_res);
    repeat (150) @(negedge clk);
    issue(16'd5, 16'd3, 16'd13);
    consume(0, 1'b0, lat);
    chk("after_abort_result", result, 8);

    issue(16'd500, 16'd1, 16'd497);
    consume(20, 1'b1, lat);
    chk("stall_result", result, 3);

    issue(16'd9, 16'hBEEF, 16'hFFF1);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    e_live = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_count", mult_count, 0);
    repeat (200) @(negedge clk);
    issue(16'd9, 16'hBEEF, 16'hFFF1);
    consume(1, 1'b0, lat);

    for (int n = 0; n < 30; n++) begin
      rb = W'($urandom);
      rm = W'($urandom) | W'(1);
      re = W'($urandom) >> $urandom_range(0, 15);
      issue(rb, re, rm);
      consume(int'($urandom_range(0, 3)), 1'b0, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_ctrl.md
RSA_MODEXP_CTRL -- requirements
Module: rsa_modexp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 1024, giving the operand, exponent, modulus and result width in bits (legal range 8..4096).
REQ-002 SHALL have parameter ODD_MOD_ONLY, default 1; when set, an even modulus is an error.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, and all logic SHALL use its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have ports start (input, 1) and in_ready (output, 1); a request is accepted on an edge where both are 1.
REQ-006 SHALL have ports base, exponent and modulus, each input, WIDTH bits; they are captured on acceptance.
REQ-007 SHALL have port abort, input, 1 bit; it cancels the operation in progress.
REQ-008 SHALL have port busy, output, 1 bit; it is 1 from acceptance until out_valid or abort.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1); the result is consumed on an edge where both are 1.
REQ-010 SHALL have port result, output, WIDTH bits, holding base^exponent mod modulus.
REQ-011 SHALL have port error, output, 1 bit; it is valid while out_valid is 1.
REQ-012 SHALL have port mult_count, output, $clog2(WIDTH)+2 bits; it counts the mod_mult operations issued for the current or last request.

Function
REQ-013 SHALL implement states IDLE, SCAN, REDUCE, SQR, MUL, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE, and SHALL ignore start in every other state.
REQ-015 On acceptance, SHALL capture the operands, clear mult_count, and go to SCAN.
- Exception: go directly to DONE with error=1 and result=0 when modulus==0, or when ODD_MOD_ONLY=1 and modulus[0]==0.
REQ-016 SCAN SHALL examine one exponent bit per cycle, from MSB down, to locate the highest set bit k.
- If no bit is set (exponent==0): go to DONE with result = (modulus==1) ? 0 : 1, issuing no multiplication.
REQ-017 REDUCE SHALL issue base*1 mod modulus, so base >= modulus is legal, and SHALL store the product as the accumulator.
REQ-018 For each bit i from k-1 down to 0, SHALL issue SQR (acc*acc), then MUL (acc*base_reduced) only if bit i==1.
REQ-019 After the last bit's operation, SHALL go to DONE; mult_count then equals 1 + k + (popcount(exponent) - 1).
REQ-020 SHALL use exactly one mod_mult instance, with one operation outstanding at most.
- Pulse mult_start for one cycle per operation; advance only on mult_done.
- mult_count increments on each mult_start.
REQ-021 In DONE, SHALL hold out_valid=1 with result and error stable until out_ready=1, then return to IDLE.
- out_valid SHALL go low on the edge where the result is consumed.
REQ-022 abort SHALL be effective in every state except IDLE and DONE, and SHALL return to IDLE on the next edge.
- On abort: assert mod_mult's internal clear, produce no out_valid, set busy=0, and leave result unchanged.
REQ-023 SHALL ignore a mult_done that arrives outside REDUCE, SQR or MUL.
REQ-024 SHALL perform all arithmetic modulo the WIDTH-bit modulus; no intermediate value exceeds WIDTH bits outside mod_mult.

Reset
REQ-025 With rst=1 at a clock edge, SHALL set: state=IDLE, in_ready=1, busy=0, out_valid=0, error=0, result=0, mult_count=0, and all internal registers to 0.
REQ-026 rst SHALL also reset mod_mult; reset mid-operation discards the operation with no out_valid.

Structure
REQ-027 SHALL place the state enum and the mod_mult handshake typedef in shared package rsa_pkg.
REQ-028 SHALL use sub-module mod_mult.
- Ports: clk, rst, clear, start, a, b, m, done, p.
- Function: Montgomery-based, with domain conversion internal, returning a*b mod m.
- Latency: variable.
- Parameter: WIDTH.

Verification (WIDTH=16 unless noted)
REQ-029 base=4, exponent=13, modulus=497 -> out_valid with result=445, error=0, mult_count=6.
REQ-030 exponent=0, modulus=497 -> result=1, mult_count=0; exponent=0, modulus=1 -> result=0.
REQ-031 modulus=496 with ODD_MOD_ONLY=1 -> error=1, result=0, out_valid within 2 cycles of acceptance; modulus=0 -> error=1.
REQ-032 abort during the second SQR of the REQ-029 operands -> in_ready=1 the next cycle, no out_valid; a following request base=5, exponent=3, modulus=13 -> result=8.
REQ-033 out_ready held low 20 cycles after out_valid -> result/error stable and start ignored; out_ready=1 -> IDLE next cycle. Also base=500, exponent=1, modulus=497 -> result=3.
REQ-034 WIDTH=1024: 200 random odd-modulus requests -> result matches the reference model's modular exponentiation, with back-to-back start and random out_ready stalls.
